// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 serial receiver with one-entry byte buffer and sticky error flags
//
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - synchronous active-low reset
//   Rxd        - asynchronous serial line, idle high
//   DataRead   - one-cycle pulse: consumer has taken RxData
//   ErrorClear - one-cycle pulse: clear FrameError and Overrun
//   RxData     - last accepted byte
//   DataValid  - RxData holds an unread byte
//   FrameError - sticky: a stop bit was sampled low
//   Overrun    - sticky: a byte was dropped because the buffer was full
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rxd,
    input  logic       DataRead,
    input  logic       ErrorClear,
    output logic [7:0] RxData,
    output logic       DataValid,
    output logic       FrameError,
    output logic       Overrun
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic            rx_prev;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rx_prev    <= 1'b1;
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            RxData     <= 8'h00;
            DataValid  <= 1'b0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            rx_meta <= Rxd;
            rxs     <= rx_meta;
            rx_prev <= rxs;

            // Clears come first so that a set later in this block overrides them.
            if (ErrorClear) begin
                FrameError <= 1'b0;
                Overrun    <= 1'b0;
            end
            if (DataRead && DataValid) begin
                DataValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Only a true 1->0 transition starts a frame, so a line
                    // held low (break, or after a framing error) stays idle.
                    if (rx_prev && !rxs) begin
                        state <= START;
                        timer <= '0;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            timer   <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        shift   <= {rxs, shift[7:1]};
                        timer   <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                        if (!rxs) begin
                            FrameError <= 1'b1;
                        end else if (!DataValid || DataRead) begin
                            // A read in the same cycle frees the slot for the new byte.
                            RxData    <= shift;
                            DataValid <= 1'b1;
                        end else begin
                            Overrun <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver with an event-level reference model
module tb_uart_receiver;

    localparam int CLOCK_FREQ = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DIV        = CLOCK_FREQ / BAUD_RATE;
    localparam int LATENCY    = 3 + DIV / 2 + 9 * DIV;

    logic       Clock;
    logic       Reset;
    logic       Rxd;
    logic       DataRead;
    logic       ErrorClear;
    logic [7:0] RxData;
    logic       DataValid;
    logic       FrameError;
    logic       Overrun;

    uart_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Rxd       (Rxd),
        .DataRead  (DataRead),
        .ErrorClear(ErrorClear),
        .RxData    (RxData),
        .DataValid (DataValid),
        .FrameError(FrameError),
        .Overrun   (Overrun)
    );

    initial begin
        Clock = 1'b0;
        forever #10 Clock = ~Clock;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rand_en = 1'b0;
    bit cmp_en  = 1'b0;
    int force_rd = -1;

    // Frame completion events: edge at which the stop bit is judged, byte, stop value.
    int         ev_edge [256];
    logic [7:0] ev_data [256];
    logic       ev_stop [256];
    int         ev_wr = 0;
    int         ev_rd = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;

    int   rise_cyc = -1;
    logic prev_dv  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: buffer/flag behaviour driven by scheduled frame outcomes.
    always @(posedge Clock) begin
        logic nvalid;
        logic [7:0] ndata;
        logic set_fe;
        logic set_ov;
        cyc = cyc + 1;
        if (!Reset) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
            ev_rd   = ev_wr;
        end else begin
            nvalid = m_valid;
            ndata  = m_data;
            set_fe = 1'b0;
            set_ov = 1'b0;
            if (DataRead && m_valid) nvalid = 1'b0;
            if (ev_rd < ev_wr && ev_edge[ev_rd] == cyc) begin
                if (!ev_stop[ev_rd]) begin
                    set_fe = 1'b1;
                end else if (!m_valid || DataRead) begin
                    ndata  = ev_data[ev_rd];
                    nvalid = 1'b1;
                end else begin
                    set_ov = 1'b1;
                end
                ev_rd = ev_rd + 1;
            end
            if (ErrorClear) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (set_fe) m_fe = 1'b1;
            if (set_ov) m_ov = 1'b1;
            m_valid = nvalid;
            m_data  = ndata;
        end
    end

    always @(negedge Clock) begin
        if (cmp_en) begin
            chk("rxdata",     32'(RxData),     32'(m_data));
            chk("datavalid",  32'(DataValid),  32'(m_valid));
            chk("frameerror", 32'(FrameError), 32'(m_fe));
            chk("overrun",    32'(Overrun),    32'(m_ov));
        end
        if (DataValid === 1'b1 && prev_dv === 1'b0) rise_cyc = cyc;
        prev_dv = DataValid;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        if (rand_en) begin
            DataRead   = ($urandom_range(0, 5) == 0);
            ErrorClear = ($urandom_range(0, 40) == 0);
        end else begin
            DataRead   = 1'b0;
            ErrorClear = 1'b0;
        end
        if (cyc == force_rd) DataRead = 1'b1;
    endtask

    // Drives one 8N1 frame, DIV clocks per bit; optional reset pulse inside slot rst_slot.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input bit rd_at_stop,
                              input int rst_slot);
        ev_edge[ev_wr] = cyc + LATENCY;
        ev_data[ev_wr] = d;
        ev_stop[ev_wr] = stopb;
        if (rd_at_stop) force_rd = cyc + LATENCY - 1;
        ev_wr = ev_wr + 1;
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < DIV; j++) begin
                Rxd   = (s == 0) ? 1'b0 : (s == 9) ? stopb : d[s-1];
                Reset = !(s == rst_slot && j < 2);
                tick();
            end
        end
    endtask

    initial begin
        int c0;
        Rxd = 1'b1; Reset = 1'b0; DataRead = 1'b0; ErrorClear = 1'b0;

        // Reset values
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("rst_rxdata", 32'(RxData), 32'h00);
        chk("rst_valid",  32'(DataValid), 32'h0);
        chk("rst_fe",     32'(FrameError), 32'h0);
        chk("rst_ov",     32'(Overrun), 32'h0);
        Reset = 1'b1;
        repeat (5) tick();

        // Single byte, latency, read
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        Rxd = 1'b1;
        tick();
        chk("a5_latency", 32'(rise_cyc - c0), 32'd98);
        chk("a5_data", 32'(RxData), 32'hA5);
        chk("a5_model", 32'(m_data), 32'hA5);
        DataRead = 1'b1;
        tick();
        chk("a5_read_valid", 32'(DataValid), 32'h0);
        chk("a5_read_data",  32'(RxData), 32'hA5);

        // Overrun, clear, read in the stop-sample cycle
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        Rxd = 1'b1;
        tick();
        chk("ovr_data",  32'(RxData), 32'h3C);
        chk("ovr_flag",  32'(Overrun), 32'h1);
        chk("ovr_model", 32'(m_ov), 32'h1);
        ErrorClear = 1'b1;
        tick();
        chk("ovr_clear", 32'(Overrun), 32'h0);
        send_frame(8'h11, 1'b1, 1'b1, -1);
        Rxd = 1'b1;
        tick();
        chk("simrd_data",  32'(RxData), 32'h11);
        chk("simrd_valid", 32'(DataValid), 32'h1);
        chk("simrd_ov",    32'(Overrun), 32'h0);

        // Framing error followed by break
        send_frame(8'h55, 1'b0, 1'b0, -1);
        Rxd = 1'b0;
        repeat (50) tick();
        chk("fe_flag",  32'(FrameError), 32'h1);
        chk("fe_valid", 32'(DataValid), 32'h1);
        chk("fe_data",  32'(RxData), 32'h11);
        Rxd = 1'b1;
        tick();
        DataRead = 1'b1;
        repeat (4) tick();
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        Rxd = 1'b1;
        tick();
        chk("brk_next_data", 32'(RxData), 32'h0F);

        // Glitch on the line
        DataRead = 1'b1; ErrorClear = 1'b1;
        repeat (3) tick();
        Rxd = 1'b0;
        repeat (3) tick();
        Rxd = 1'b1;
        repeat (20) tick();
        chk("gl_valid", 32'(DataValid), 32'h0);
        chk("gl_fe",    32'(FrameError), 32'h0);
        chk("gl_ov",    32'(Overrun), 32'h0);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        Rxd = 1'b1;
        tick();
        chk("gl_next_data", 32'(RxData), 32'hC3);

        // Reset during bit 4
        send_frame(8'hFF, 1'b1, 1'b0, 5);
        Rxd = 1'b1;
        tick();
        chk("mrst_data",  32'(RxData), 32'h00);
        chk("mrst_valid", 32'(DataValid), 32'h0);
        chk("mrst_fe",    32'(FrameError), 32'h0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        Rxd = 1'b1;
        tick();
        chk("mrst_next_data", 32'(RxData), 32'h81);

        // Random frames, gaps, reads and clears
        rand_en = 1'b1;
        begin
            logic stopb;
            logic prev_stop;
            int   gap;
            prev_stop = 1'b1;
            for (int f = 0; f < 40; f++) begin
                stopb = ($urandom_range(0, 9) != 0);
                gap   = prev_stop ? $urandom_range(0, 12) : $urandom_range(1, 12);
                for (int g = 0; g < gap; g++) begin
                    Rxd = 1'b1;
                    tick();
                end
                send_frame(8'($urandom), stopb, ($urandom_range(0, 3) == 0), -1);
                prev_stop = stopb;
            end
        end
        Rxd = 1'b1;
        repeat (20) tick();
        rand_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage between the `Rxd` chip pin and the SystemChip I/O bus. It synchronises the asynchronous line, detects 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit), and samples each bit at mid-bit. It holds the received byte in a one-entry buffer with a valid/read handshake and sticky framing and overrun flags for the bus-side consumer.

## Interface
- `CLOCK_FREQ`, default 50_000_000: system clock frequency in Hz (20 ns period).
- `BAUD_RATE`, default 115200: line bit rate.
- `DIV`, derived as `CLOCK_FREQ/BAUD_RATE` (integer division, 434 at defaults): clocks per bit. `DIV` ≥ 4 is required.
- `Clock`, in, 1: system clock; all logic on the rising edge.
- `Reset`, in, 1: synchronous, active-low reset.
- `Rxd`, in, 1: asynchronous serial line, idle high.
- `DataRead`, in, 1: one-cycle pulse from the consumer meaning "byte taken".
- `ErrorClear`, in, 1: one-cycle pulse that clears `FrameError` and `Overrun`.
- `RxData`, out, 8: last accepted byte.
- `DataValid`, out, 1: `RxData` holds an unread byte.
- `FrameError`, out, 1: sticky; a stop bit was sampled low.
- `Overrun`, out, 1: sticky; a byte was lost because the buffer was full.

## Operation
- **Synchroniser.** Two flops on `Rxd`, both reset to 1. A third flop holds the previous synchronised value for edge detection. All decisions use the synchronised line `RxS`.
- **Bit timer.** Counter of width `$clog2(DIV)`, reset to 0. Bit index counter 0..7.
- **IDLE.**
  - Go to START on a falling edge of `RxS` (previous 1, current 0) and clear the timer.
  - A line that is continuously low never starts a frame. This also covers break and the period after a framing error.
- **START.**
  - When the timer reaches `DIV/2 - 1`, sample `RxS`.
  - If `RxS` = 1, the start was a glitch: go to IDLE with no flags changed.
  - If `RxS` = 0, go to DATA, clear the timer and clear the bit index.
- **DATA.**
  - Each time the timer reaches `DIV - 1`, sample `RxS` into the shift register (LSB first), clear the timer and increment the index.
  - After bit 7, go to STOP.
- **STOP.** When the timer reaches `DIV - 1`, sample `RxS` and go to IDLE.
  - `RxS` = 1, `DataValid` = 0: load `RxData`, set `DataValid`.
  - `RxS` = 1, `DataValid` = 1, `DataRead` = 1 in the same cycle: load the new byte; `DataValid` stays 1; no overrun.
  - `RxS` = 1, `DataValid` = 1, `DataRead` = 0: discard the new byte, keep the old byte, set `Overrun`.
  - `RxS` = 0: discard the byte, set `FrameError`; `DataValid`/`RxData` unchanged.
- **Read side.** `DataRead` while `DataValid` = 1 clears `DataValid` next cycle; `RxData` keeps its value. `DataRead` while `DataValid` = 0 is ignored.
- **Error flags.** `ErrorClear` clears both flags. If a set event and `ErrorClear` occur in the same cycle, set wins.
- **Reset.**
  - `Reset` = 0 at any rising edge, including mid-frame: state IDLE, all counters 0, synchroniser flops 1, `RxData` = 8'h00, `DataValid` = 0, `FrameError` = 0, `Overrun` = 0.
  - A frame in progress at reset is dropped.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Edge detection is 3 clocks after the `Rxd` pin falls (2 synchroniser flops + edge register).
- Start sample is `DIV/2` clocks after detection. Each data bit is sampled `DIV` clocks after the previous sample; the stop bit is sampled `DIV` after bit 7.
- `DataValid` is high in the cycle after the stop sample, about `3 + DIV/2 + 9*DIV` clocks after the pin falls.
- A new frame may start in the cycle after the stop sample; back-to-back frames with a 1-bit stop are supported.
- Tolerated baud mismatch is at least ±3% at `DIV` ≥ 16.

## Test plan
All scenarios use `CLOCK_FREQ` = 1_000_000 and `BAUD_RATE` = 100_000, so `DIV` = 10.
1. **Reset values.** Hold `Reset` = 0 for 3 clocks with `Rxd` = 1 → `RxData` = 00, `DataValid` = 0, both flags 0.
2. **Single byte and read.** Send 8'hA5 (8N1) → `DataValid` rises 3+5+90 = 98 clocks after the start edge, `RxData` = A5. Pulse `DataRead` → `DataValid` = 0 next cycle, `RxData` still A5.
3. **Overrun and simultaneous read.**
   - Send 8'h3C and 8'h7E back-to-back without reading → `RxData` = 3C, `Overrun` = 1.
   - Pulse `ErrorClear` → `Overrun` = 0.
   - Send 8'h11 with `DataRead` asserted exactly in the stop-sample cycle → `RxData` = 11, `DataValid` = 1, `Overrun` = 0.
4. **Framing error and break.** Send 8'h55 with the stop bit low, then hold `Rxd` low for 50 clocks → `FrameError` = 1, `DataValid` unchanged, no new frame starts. Release `Rxd` and send 8'h0F → `RxData` = 0F.
5. **Glitch.** Pulse `Rxd` low for 3 clocks → no byte, no flags, FSM back in IDLE; a following 8'hC3 is received correctly.
6. **Mid-frame reset.** Assert `Reset` = 0 during bit 4 of 8'hFF → all outputs at reset values; a following 8'h81 is received correctly.
